// File: rtl/bsg_fifo_1r1w_tracked_if.sv
// Handshake, data and status bundle for bsg_fifo_1r1w_tracked.
// The FIFO connects through the slave modport; the producer/consumer side uses master.
interface bsg_fifo_1r1w_tracked_if #(
  parameter int width_p = 32,
  parameter int els_p   = 64
);
  localparam int count_width_lp = $clog2(els_p + 1);

  logic                      v_i;
  logic [width_p-1:0]        data_i;
  logic                      ready_o;
  logic                      v_o;
  logic [width_p-1:0]        data_o;
  logic                      yumi_i;
  logic [count_width_lp-1:0] count_o;
  logic                      full_o;
  logic                      empty_o;

  modport master (
    output v_i, data_i, yumi_i,
    input  ready_o, v_o, data_o, count_o, full_o, empty_o
  );

  modport slave (
    input  v_i, data_i, yumi_i,
    output ready_o, v_o, data_o, count_o, full_o, empty_o
  );
endinterface

// File: rtl/bsg_fifo_1r1w_tracked.sv
// Single-clock ready/valid-in, valid/yumi-out FIFO built on a circular
// read/write pointer pair with last-operation flags to split full from empty.
module bsg_fifo_1r1w_tracked_chk (
  input logic clk_i,
  input logic reset_n_i,
  input logic yumi_i,
  input logic v_o,
  input logic full_o,
  input logic empty_o
);
  // Consumer may only take an entry that is actually presented.
  a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(yumi_i && !v_o));

  // The two status flags are mutually exclusive.
  a_full_empty_excl: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(full_o && empty_o));
endmodule

module bsg_fifo_1r1w_tracked #(
  parameter int width_p = 32,
  parameter int els_p   = 64
) (
  input logic                   clk_i,
  input logic                   reset_n_i,
  bsg_fifo_1r1w_tracked_if.slave fifo_if
);
  localparam int ptr_width_lp   = $clog2(els_p);
  localparam int count_width_lp = $clog2(els_p + 1);

  logic [ptr_width_lp-1:0]   wptr_r;
  logic [ptr_width_lp-1:0]   rptr_r;
  logic                      enq_last_r;
  logic                      deq_last_r;
  logic [count_width_lp-1:0] count_r;
  logic [width_p-1:0]        mem_r [els_p];

  logic enq_s;
  logic deq_s;
  logic ptr_eq_s;
  logic full_s;
  logic empty_s;
  logic ready_s;
  logic v_s;

  // Explicit wrap compare keeps non-power-of-two depths correct.
  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] ptr);
    logic [ptr_width_lp-1:0] nxt;
    if (ptr == ptr_width_lp'(els_p - 1)) begin
      nxt = {ptr_width_lp{1'b0}};
    end else begin
      nxt = ptr + ptr_width_lp'(1);
    end
    return nxt;
  endfunction

  // Handshake decode and full/empty derivation from pointers and last-op flags.
  always_comb begin
    ptr_eq_s = (rptr_r == wptr_r);
    empty_s  = ptr_eq_s & deq_last_r;
    full_s   = ptr_eq_s & enq_last_r & ~deq_last_r;
    ready_s  = ~full_s & reset_n_i;
    v_s      = ~empty_s;
    enq_s    = fifo_if.v_i & ready_s;
    deq_s    = fifo_if.yumi_i;
  end

  // Pointer, last-op flag and occupancy state.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r     <= {ptr_width_lp{1'b0}};
      rptr_r     <= {ptr_width_lp{1'b0}};
      enq_last_r <= 1'b0;
      deq_last_r <= 1'b1;
      count_r    <= {count_width_lp{1'b0}};
    end else begin
      if (enq_s) begin
        wptr_r <= ptr_inc(wptr_r);
      end
      if (deq_s) begin
        rptr_r <= ptr_inc(rptr_r);
      end
      // Flags hold across idle cycles so the equal-pointer case stays resolved.
      if (enq_s | deq_s) begin
        enq_last_r <= enq_s;
        deq_last_r <= deq_s;
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + count_width_lp'(1);
        2'b01:   count_r <= count_r - count_width_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (enq_s) begin
      mem_r[wptr_r] <= fifo_if.data_i;
    end
  end

  assign fifo_if.ready_o = ready_s;
  assign fifo_if.v_o     = v_s;
  assign fifo_if.data_o  = mem_r[rptr_r];
  assign fifo_if.count_o = count_r;
  assign fifo_if.full_o  = full_s;
  assign fifo_if.empty_o = empty_s;

  bsg_fifo_1r1w_tracked_chk chk (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .yumi_i    (fifo_if.yumi_i),
    .v_o       (v_s),
    .full_o    (full_s),
    .empty_o   (empty_s)
  );
endmodule

// File: tb/tb_bsg_fifo_1r1w_tracked.sv
// Directed bench for bsg_fifo_1r1w_tracked at depths 4 and 5, checked every
// cycle against queue models plus hand-computed literal expectations.
module tb_bsg_fifo_1r1w_tracked;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errs  = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bsg_fifo_1r1w_tracked_if #(.width_p(8), .els_p(4)) if4 ();
  bsg_fifo_1r1w_tracked_if #(.width_p(8), .els_p(5)) if5 ();

  bsg_fifo_1r1w_tracked #(.width_p(8), .els_p(4)) dut4 (
    .clk_i(clk), .reset_n_i(rst_n), .fifo_if(if4.slave)
  );
  bsg_fifo_1r1w_tracked #(.width_p(8), .els_p(5)) dut5 (
    .clk_i(clk), .reset_n_i(rst_n), .fifo_if(if5.slave)
  );

  logic [7:0] q4[$];
  logic [7:0] q5[$];

  // Queue models: accept when below capacity and out of reset, pop on yumi.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q4.delete();
      q5.delete();
    end else begin
      automatic bit e4 = if4.v_i && (q4.size() < 4);
      automatic bit e5 = if5.v_i && (q5.size() < 5);
      if (if4.yumi_i && q4.size() > 0) void'(q4.pop_front());
      if (if5.yumi_i && q5.size() > 0) void'(q5.pop_front());
      if (e4) q4.push_back(if4.data_i);
      if (e5) q5.push_back(if5.data_i);
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_models();
    cmp("m4.ready", 32'(if4.ready_o), 32'(rst_n && q4.size() < 4));
    cmp("m4.v",     32'(if4.v_o),     32'(q4.size() > 0));
    cmp("m4.full",  32'(if4.full_o),  32'(q4.size() == 4));
    cmp("m4.empty", 32'(if4.empty_o), 32'(q4.size() == 0));
    cmp("m4.count", 32'(if4.count_o), 32'(q4.size()));
    if (q4.size() > 0) cmp("m4.data", 32'(if4.data_o), 32'(q4[0]));
    cmp("m5.ready", 32'(if5.ready_o), 32'(rst_n && q5.size() < 5));
    cmp("m5.v",     32'(if5.v_o),     32'(q5.size() > 0));
    cmp("m5.full",  32'(if5.full_o),  32'(q5.size() == 5));
    cmp("m5.empty", 32'(if5.empty_o), 32'(q5.size() == 0));
    cmp("m5.count", 32'(if5.count_o), 32'(q5.size()));
    if (q5.size() > 0) cmp("m5.data", 32'(if5.data_o), 32'(q5[0]));
  endtask

  task automatic cyc4(input logic v, input logic [7:0] d, input logic y);
    if4.v_i = v; if4.data_i = d; if4.yumi_i = y;
    @(posedge clk); #1;
    if4.v_i = 1'b0; if4.yumi_i = 1'b0;
  endtask

  task automatic cyc5(input logic v, input logic [7:0] d, input logic y);
    if5.v_i = v; if5.data_i = d; if5.yumi_i = y;
    @(posedge clk); #1;
    if5.v_i = 1'b0; if5.yumi_i = 1'b0;
  endtask

  initial begin
    if4.v_i = 1'b0; if4.data_i = 8'h00; if4.yumi_i = 1'b0;
    if5.v_i = 1'b0; if5.data_i = 8'h00; if5.yumi_i = 1'b0;
    fork
      forever begin
        @(negedge clk);
        compare_models();
      end
    join_none

    // Reset release
    repeat (3) @(posedge clk);
    #1;
    cmp("rst.v",     32'(if4.v_o),     32'd0);
    cmp("rst.empty", 32'(if4.empty_o), 32'd1);
    cmp("rst.count", 32'(if4.count_o), 32'd0);
    cmp("rst.ready", 32'(if4.ready_o), 32'd0);
    rst_n = 1'b1;
    #1;
    cmp("rel.ready", 32'(if4.ready_o), 32'd1);
    cmp("rel.ready5", 32'(if5.ready_o), 32'd1);

    // Fill to full, reject a fifth word, then drain in order
    for (int i = 0; i < 4; i++) cyc4(1'b1, 8'hA0 + 8'(i), 1'b0);
    cmp("fill.count", 32'(if4.count_o), 32'd4);
    cmp("fill.full",  32'(if4.full_o),  32'd1);
    cmp("fill.ready", 32'(if4.ready_o), 32'd0);
    cyc4(1'b1, 8'hEE, 1'b0);
    cmp("fill.reject", 32'(if4.count_o), 32'd4);
    for (int i = 0; i < 4; i++) begin
      cmp("drain.data", 32'(if4.data_o), 32'hA0 + 32'(i));
      cyc4(1'b0, 8'h00, 1'b1);
    end
    cmp("drain.empty", 32'(if4.empty_o), 32'd1);

    // Enq+deq offered while full: only the dequeue happens
    for (int i = 0; i < 4; i++) cyc4(1'b1, 8'hB0 + 8'(i), 1'b0);
    cmp("sim.full", 32'(if4.full_o), 32'd1);
    cyc4(1'b1, 8'hCC, 1'b1);
    cmp("sim.count", 32'(if4.count_o), 32'd3);
    cmp("sim.ready", 32'(if4.ready_o), 32'd1);
    for (int i = 1; i < 4; i++) begin
      cmp("sim.data", 32'(if4.data_o), 32'hB0 + 32'(i));
      cyc4(1'b0, 8'h00, 1'b1);
    end

    // One-cycle latency, no fall-through
    if4.v_i = 1'b1; if4.data_i = 8'h55;
    #1;
    cmp("lat.same", 32'(if4.v_o), 32'd0);
    @(posedge clk); #1;
    if4.v_i = 1'b0;
    cmp("lat.v",    32'(if4.v_o),    32'd1);
    cmp("lat.data", 32'(if4.data_o), 32'h55);
    cyc4(1'b0, 8'h00, 1'b1);

    // Depth-5 streaming through two pointer wraps
    cyc5(1'b1, 8'h10, 1'b0);
    for (int k = 1; k < 12; k++) begin
      cmp("wrap.data", 32'(if5.data_o), 32'h10 + 32'(k - 1));
      cyc5(1'b1, 8'h10 + 8'(k), 1'b1);
      cmp("wrap.count", 32'(if5.count_o), 32'd1);
    end
    cmp("wrap.last", 32'(if5.data_o), 32'h1B);
    cyc5(1'b0, 8'h00, 1'b1);
    cmp("wrap.empty", 32'(if5.empty_o), 32'd1);

    // Asynchronous reset between edges discards queued entries
    for (int i = 0; i < 3; i++) cyc4(1'b1, 8'h31 + 8'(i), 1'b0);
    cmp("mid.count", 32'(if4.count_o), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    cmp("mid.empty", 32'(if4.empty_o), 32'd1);
    cmp("mid.cnt0",  32'(if4.count_o), 32'd0);
    cmp("mid.ready", 32'(if4.ready_o), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    cyc4(1'b1, 8'h77, 1'b0);
    cmp("post.v",     32'(if4.v_o),     32'd1);
    cmp("post.data",  32'(if4.data_o),  32'h77);
    cmp("post.count", 32'(if4.count_o), 32'd1);
    cyc4(1'b0, 8'h00, 1'b1);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
